lcd_pll_seq: RTL and testbench

- Power-up and restart sequencer for the LCD PLL (24 MHz refclk in; pixel, bus and aux clocks out).
- Runs entirely on refclk, so it works while the PLL is unlocked.
- Drives the PLL's active-high reset, holds it for a fixed time, then waits a settle time.
- Releases the three downstream clock-domain resets in staggered order, then reports ready. Supports a software restart and, optionally, lock supervision with retry.

---
 rtl/lcd_pll_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_lcd_pll_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pll_seq.sv
// -----------------------------------------------------------------------------
// lcd_pll_seq
//
// Power-up and restart sequencer for the LCD PLL. Runs only on the 24 MHz
// reference clock, so it keeps working while the PLL is unlocked.
//
// Sequence: hold pll_reset high for RST_CYCLES, wait SETTLE_CYCLES for the
// PLL to settle, release the three domain resets one at a time, STAGGER_CYCLES
// apart, then raise ready. A single-cycle restart_req sends the sequencer back
// to the start from any state except the initial reset hold.
//
// Build option: define PLL_LOCK_CHK_EN to enable lock supervision. The lock
// indication is then synchronised and checked at the end of SETTLE, with a
// bounded number of retries before FAULT. It is also watched through a
// LOCK_FILT-cycle filter while the domains are being released or running.
// With the macro undefined, pll_lock is ignored and fault/retry_cnt read 0.
//
// Ports:
//   refclk      in   PLL reference clock, only clock of this block
//   reset_n     in   asynchronous active-low reset
//   restart_req in   single-cycle restart request (refclk domain)
//   pll_lock    in   PLL lock, asynchronous (lock-check build only)
//   pll_reset   out  active-high reset to the PLL
//   dom_rst_n   out  [2:0] active-low resets for clk0/clk1/clk2 domains
//   ready       out  all domains released
//   fault       out  lock failed MAX_RETRY times
//   retry_cnt   out  [3:0] failed lock attempts since last RUN entry (sat. 15)
// -----------------------------------------------------------------------------
module lcd_pll_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 4800,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRY      = 3,
  parameter int LOCK_FILT      = 4
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       restart_req,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [2:0] dom_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  // One timer serves every timed state; size it for the longest interval.
  localparam int TIMER_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_MAX   = (TIMER_MAX_A > STAGGER_CYCLES) ? TIMER_MAX_A : STAGGER_CYCLES;
  localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STAG_LAST   = TIMER_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t             state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               pll_reset_r;
  logic [2:0]         dom_rst_n_r;
  logic               ready_r;
  logic               lock_lost_s;

`ifdef PLL_LOCK_CHK_EN
  localparam int               FILT_W      = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILT - 1);
  localparam logic [3:0]       MAX_RETRY_V = 4'(MAX_RETRY);

  logic              lock_meta_r;
  logic              lock_s_r;
  logic [FILT_W-1:0] lo_cnt_r;
  logic              fault_r;
  logic [3:0]        retry_cnt_r;
  logic [3:0]        retry_inc_s;
  logic              supervised_s;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_s_r    <= lock_meta_r;
    end
  end

  // Saturating next value of the failed-attempt counter
  always_comb begin
    retry_inc_s = retry_cnt_r;
    if (retry_cnt_r == 4'd15) begin
      retry_inc_s = 4'd15;
    end else begin
      retry_inc_s = retry_cnt_r + 4'd1;
    end
  end

  // Lock loss: the LOCK_FILT-th consecutive unlocked edge while supervised
  always_comb begin
    supervised_s = 1'b0;
    lock_lost_s  = 1'b0;
    if ((state_r == ST_RELEASE) || (state_r == ST_RUN)) begin
      supervised_s = 1'b1;
    end else begin
      supervised_s = 1'b0;
    end
    if (supervised_s && !lock_s_r && (lo_cnt_r == FILT_LAST)) begin
      lock_lost_s = 1'b1;
    end else begin
      lock_lost_s = 1'b0;
    end
  end

  // Consecutive-unlocked counter; any locked sample or unsupervised state clears it
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      lo_cnt_r <= '0;
    end else if (supervised_s && !lock_s_r && !lock_lost_s) begin
      lo_cnt_r <= lo_cnt_r + FILT_W'(1);
    end else begin
      lo_cnt_r <= '0;
    end
  end

  assign fault     = fault_r;
  assign retry_cnt = retry_cnt_r;
`else
  // Lock input and lock-check parameters have no function in this build.
  logic unused_lock_s;
  assign unused_lock_s = pll_lock | (MAX_RETRY == 0) | (LOCK_FILT == 0);
  assign lock_lost_s   = 1'b0;
  assign fault         = 1'b0;
  assign retry_cnt     = 4'd0;
`endif

  // Sequencer: state, shared timer and all registered outputs
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RST;
      timer_r     <= '0;
      pll_reset_r <= 1'b1;
      dom_rst_n_r <= 3'b000;
      ready_r     <= 1'b0;
`ifdef PLL_LOCK_CHK_EN
      fault_r     <= 1'b0;
      retry_cnt_r <= 4'd0;
`endif
    end else begin
      case (state_r)
        // PLL held in reset; restart_req is ignored so the hold is never stretched
        ST_RST: begin
          if (timer_r == RST_LAST) begin
            state_r     <= ST_SETTLE;
            timer_r     <= '0;
            pll_reset_r <= 1'b0;
          end else begin
            timer_r     <= timer_r + TIMER_ONE;
          end
        end

        ST_SETTLE: begin
          if (restart_req) begin
            state_r     <= ST_RST;
            timer_r     <= '0;
            pll_reset_r <= 1'b1;
            dom_rst_n_r <= 3'b000;
            ready_r     <= 1'b0;
          end else if (timer_r == SETTLE_LAST) begin
            timer_r <= '0;
`ifdef PLL_LOCK_CHK_EN
            if (lock_s_r) begin
              state_r     <= ST_RELEASE;
              dom_rst_n_r <= 3'b001;
            end else if (retry_inc_s == MAX_RETRY_V) begin
              // Out of attempts: park with the PLL held in reset
              state_r     <= ST_FAULT;
              fault_r     <= 1'b1;
              pll_reset_r <= 1'b1;
              retry_cnt_r <= retry_inc_s;
            end else begin
              state_r     <= ST_RST;
              pll_reset_r <= 1'b1;
              retry_cnt_r <= retry_inc_s;
            end
`else
            state_r     <= ST_RELEASE;
            dom_rst_n_r <= 3'b001;
`endif
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end

        // Staggered release; the dom_rst_n bits themselves track progress
        ST_RELEASE: begin
          if (restart_req || lock_lost_s) begin
            state_r     <= ST_RST;
            timer_r     <= '0;
            pll_reset_r <= 1'b1;
            dom_rst_n_r <= 3'b000;
            ready_r     <= 1'b0;
          end else if (!dom_rst_n_r[1]) begin
            if (timer_r == STAG_LAST) begin
              dom_rst_n_r <= 3'b011;
              timer_r     <= '0;
            end else begin
              timer_r     <= timer_r + TIMER_ONE;
            end
          end else if (!dom_rst_n_r[2]) begin
            if (timer_r == STAG_LAST) begin
              dom_rst_n_r <= 3'b111;
              timer_r     <= '0;
            end else begin
              timer_r     <= timer_r + TIMER_ONE;
            end
          end else begin
            state_r <= ST_RUN;
            timer_r <= '0;
            ready_r <= 1'b1;
`ifdef PLL_LOCK_CHK_EN
            retry_cnt_r <= 4'd0;
`endif
          end
        end

        ST_RUN: begin
          if (restart_req || lock_lost_s) begin
            state_r     <= ST_RST;
            timer_r     <= '0;
            pll_reset_r <= 1'b1;
            dom_rst_n_r <= 3'b000;
            ready_r     <= 1'b0;
          end else begin
            state_r <= ST_RUN;
          end
        end

        // Only restart_req (or reset_n) leaves FAULT
        ST_FAULT: begin
          if (restart_req) begin
            state_r     <= ST_RST;
            timer_r     <= '0;
            pll_reset_r <= 1'b1;
            dom_rst_n_r <= 3'b000;
            ready_r     <= 1'b0;
`ifdef PLL_LOCK_CHK_EN
            fault_r     <= 1'b0;
            retry_cnt_r <= 4'd0;
`endif
          end else begin
            state_r <= ST_FAULT;
          end
        end

        default: begin
          state_r     <= ST_RST;
          timer_r     <= '0;
          pll_reset_r <= 1'b1;
          dom_rst_n_r <= 3'b000;
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset = pll_reset_r;
  assign dom_rst_n = dom_rst_n_r;
  assign ready     = ready_r;

endmodule

// File: tb/tb_lcd_pll_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_pll_seq: self-checking bench for lcd_pll_seq (default parameters).
// A reference model expresses the expected outputs as a function of how many
// edges have passed since the current attempt began. The stimulus process
// pushes one expected snapshot per edge. A monitor pops and compares it on
// the following falling edge, or immediately after an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_lcd_pll_seq;

  localparam int RST_C    = 16;
  localparam int SETTLE_C = 4800;
  localparam int STAG_C   = 8;
  localparam int T_REL0   = RST_C + SETTLE_C;  // dom_rst_n = 001
  localparam int T_REL1   = T_REL0 + STAG_C;   // dom_rst_n = 011
  localparam int T_REL2   = T_REL1 + STAG_C;   // dom_rst_n = 111
  localparam int T_RDY    = T_REL2 + 1;        // ready = 1
`ifdef PLL_LOCK_CHK_EN
  localparam int MAX_RETRY = 3;
  localparam int LOCK_FILT = 4;
`endif

  logic       refclk      = 1'b0;
  logic       reset_n     = 1'b1;
  logic       restart_req = 1'b0;
  logic       pll_lock    = 1'b0;
  logic       pll_reset;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  lcd_pll_seq dut (
    .refclk      (refclk),
    .reset_n     (reset_n),
    .restart_req (restart_req),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .dom_rst_n   (dom_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt)
  );

  always #5 refclk = ~refclk;

  // expected snapshot: {pll_reset, dom_rst_n, ready, fault, retry_cnt}
  typedef struct {
    int         e;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event chk_ev;

  // reference model state
  int edge_n    = 0;
  int seq_start = 0;
  int m_retry   = 0;
  bit m_fault   = 1'b0;
`ifdef PLL_LOCK_CHK_EN
  int low_run = 0;
  bit h1 = 1'b0;
  bit h2 = 1'b0;
`endif

  function automatic logic [9:0] snap_for(int k, bit flt, int rc);
    logic       p;
    logic [2:0] d;
    logic       r;
    if (flt)            begin p = 1'b1; d = 3'b000; r = 1'b0; end
    else if (k < RST_C) begin p = 1'b1; d = 3'b000; r = 1'b0; end
    else if (k < T_REL0) begin p = 1'b0; d = 3'b000; r = 1'b0; end
    else if (k < T_REL1) begin p = 1'b0; d = 3'b001; r = 1'b0; end
    else if (k < T_REL2) begin p = 1'b0; d = 3'b011; r = 1'b0; end
    else if (k < T_RDY)  begin p = 1'b0; d = 3'b111; r = 1'b0; end
    else                 begin p = 1'b0; d = 3'b111; r = 1'b1; end
    return {p, d, r, flt, 4'(rc)};
  endfunction

  function automatic logic lk_idle();
`ifdef PLL_LOCK_CHK_EN
    return 1'b1;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  // One clock: drive inputs, advance the model over the edge, queue expectation
  task automatic step(input logic rq, input logic lk);
    int kp;
    bit lost;
    bit lock_ok;
    exp_t x;
    restart_req = rq;
    pll_lock    = lk;
    @(posedge refclk);
    edge_n++;
    kp      = edge_n - 1 - seq_start;  // edges into the attempt before this edge
    lost    = 1'b0;
    lock_ok = 1'b1;
`ifdef PLL_LOCK_CHK_EN
    lock_ok = h2;                      // lock seen two edges late
    h2 = h1;
    h1 = lk;
    if (!m_fault && kp >= T_REL0 && !lock_ok) begin
      low_run++;
      lost = (low_run == LOCK_FILT);
    end else begin
      low_run = 0;
    end
    if (lost || rq) low_run = 0;
`endif
    if (m_fault) begin
      if (rq) begin
        m_fault   = 1'b0;
        m_retry   = 0;
        seq_start = edge_n;
      end
    end else if (kp >= RST_C) begin
      if (rq || lost) begin
        seq_start = edge_n;
      end else if (kp == T_REL0 - 1 && !lock_ok) begin
        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
`ifdef PLL_LOCK_CHK_EN
        if (m_retry == MAX_RETRY) m_fault = 1'b1;
        else seq_start = edge_n;
`endif
      end
    end
    if (!m_fault && (edge_n - seq_start) == T_RDY) m_retry = 0;
    x.e = edge_n;
    x.v = snap_for(edge_n - seq_start, m_fault, m_retry);
    exp_q.push_back(x);
    #1;
  endtask

  // Assert reset_n mid-cycle, check reset values before any clock edge, release
  task automatic apply_reset();
    exp_t x;
    @(negedge refclk);
    #1;
    restart_req = 1'b0;
    reset_n     = 1'b0;
    #1;
    x.e = -1;
    x.v = {1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
    exp_q.push_back(x);
    ->chk_ev;
    @(posedge refclk);
    #1;
    @(posedge refclk);
    #1;
    reset_n   = 1'b1;
    edge_n    = 0;
    seq_start = 0;
    m_retry   = 0;
    m_fault   = 1'b0;
`ifdef PLL_LOCK_CHK_EN
    low_run = 0;
    h1      = 1'b0;
    h2      = 1'b0;
`endif
  endtask

  // Monitor: compare DUT outputs against every queued expectation
  initial begin : monitor
    exp_t       x;
    logic [9:0] act;
    forever begin
      @(negedge refclk or chk_ev);
      while (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {pll_reset, dom_rst_n, ready, fault, retry_cnt};
        n_checks++;
        if (act === x.v) begin
          n_pass++;
        end else begin
          $display("FAIL outputs@edge%0d: got pll_reset=%b dom_rst_n=%b ready=%b fault=%b retry_cnt=%0d, expected pll_reset=%b dom_rst_n=%b ready=%b fault=%b retry_cnt=%0d",
                   x.e, act[9], act[8:6], act[5], act[4], act[3:0],
                   x.v[9], x.v[8:6], x.v[5], x.v[4], x.v[3:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #(1_200_000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d;
    #1 reset_n = 1'b0;
    apply_reset();

    // Power-up timeline; restart requests during the PLL reset hold (incl. edge 5)
    for (int i = 1; i <= T_RDY + 8; i++)
      step((i == 5) || (i < RST_C && $urandom_range(0, 3) == 0), lk_idle());

    // Restart from RUN, full timeline repeats
    step(1'b1, lk_idle());
    for (int i = 0; i < T_RDY + 8; i++) step(1'b0, lk_idle());

    // Random restarts: anywhere, near the release window, near the RST boundary
    repeat (4) begin
      case ($urandom_range(0, 2))
        0:       d = $urandom_range(1, T_RDY + 5);
        1:       d = $urandom_range(T_REL0 - 3, T_RDY + 2);
        default: d = $urandom_range(RST_C - 2, RST_C + 2);
      endcase
      for (int i = 0; i < d; i++) step(1'b0, lk_idle());
      step(1'b1, lk_idle());
    end
    for (int i = 0; i < T_RDY + 8; i++) step(1'b0, lk_idle());

    // Asynchronous reset in the middle of the release stagger
    apply_reset();
    for (int i = 0; i < T_REL0 + 4; i++) step(1'b0, lk_idle());
    apply_reset();
    for (int i = 0; i < 40; i++) step(1'b0, lk_idle());

`ifdef PLL_LOCK_CHK_EN
    // Lock never comes: two retries, then FAULT; restart clears it
    apply_reset();
    for (int i = 0; i < 3 * T_REL0 + 20; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < T_RDY + 8; i++) step(1'b0, 1'b1);
    // Short lock drop is filtered, a LOCK_FILT-long drop restarts
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
`endif

    @(negedge refclk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
